// File: rtl/hexdisplay_pkg.sv
// Shared definitions for the seven-segment display controller: register map,
// CTRL bit positions and the hex/BCD counter step function.
package hexdisplay_pkg;

   localparam logic [1:0] ADDR_VALUE  = 2'd0;
   localparam logic [1:0] ADDR_CTRL   = 2'd1;
   localparam logic [1:0] ADDR_PERIOD = 2'd2;
   localparam logic [1:0] ADDR_BLANK  = 2'd3;

   localparam int CTRL_RUN  = 0;
   localparam int CTRL_DOWN = 1;
   localparam int CTRL_BCD  = 2;
   localparam int CTRL_WRAP = 8;

   localparam int MAX_DIGITS = 8;

   // Steps the low ndigits nibbles of value by one; bit 32 is the carry/borrow
   // out of the top digit. Nibbles above ndigits come back as zero.
   function automatic logic [32:0] step_value(input logic [31:0] value,
                                              input logic        down,
                                              input logic        bcd,
                                              input int          ndigits);
      logic [31:0] next;
      logic        carry;
      logic [3:0]  nib;
      next  = '0;
      carry = 1'b1;
      for (int i = 0; i < MAX_DIGITS; i++) begin
         if (i < ndigits) begin
            nib = value[4*i +: 4];
            if (carry) begin
               if (!down) begin
                  if (bcd) begin
                     if (nib >= 4'd9) nib = 4'd0;
                     else begin
                        nib   = nib + 4'd1;
                        carry = 1'b0;
                     end
                  end else begin
                     carry = (nib == 4'hF);
                     nib   = nib + 4'd1;
                  end
               end else begin
                  if (bcd) begin
                     if (nib == 4'd0) nib = 4'd9;
                     else begin
                        nib   = nib - 4'd1;
                        carry = 1'b0;
                     end
                  end else begin
                     carry = (nib == 4'h0);
                     nib   = nib - 4'd1;
                  end
               end
            end
            next[4*i +: 4] = nib;
         end
      end
      return {carry, next};
   endfunction

endpackage

// File: rtl/seg7decoder.sv
// Hex nibble to active-low seven-segment pattern (bit 0 = segment a).
module seg7decoder (
   input  logic [3:0] hex,
   output logic [6:0] seg
);

   always_comb begin
      unique case (hex)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h10;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;
         4'hD: seg = 7'h21;
         4'hE: seg = 7'h06;
         4'hF: seg = 7'h0E;
      endcase
   end

endmodule

// File: rtl/hexdisplay_ctrl.sv
// Memory-mapped NDIGITS seven-segment controller with a prescaled up/down
// hex/BCD counter, per-digit blanking and registered readback.
module hexdisplay_ctrl
   import hexdisplay_pkg::*;
#(
   parameter int                    NDIGITS    = 6,
   parameter int                    PERIOD_W   = 24,
   parameter logic [PERIOD_W-1:0]   PERIOD_RST = 24'hFFFFFF
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [1:0]             address,
   input  logic                   write,
   input  logic [31:0]            writedata,
   input  logic                   read,
   output logic [31:0]            readdata,
   output logic [7*NDIGITS-1:0]   HEX
);

   localparam int VW = 4 * NDIGITS;

   logic [VW-1:0]       value_q,    value_d;
   logic                run_q,      run_d;
   logic                down_q,     down_d;
   logic                bcd_q,      bcd_d;
   logic                wrap_q,     wrap_d;
   logic [PERIOD_W-1:0] period_q,   period_d;
   logic [NDIGITS-1:0]  blank_q,    blank_d;
   logic [PERIOD_W-1:0] presc_q,    presc_d;
   logic [31:0]         readdata_q, readdata_d;

   logic                tick;
   logic                value_wr;
   logic [32:0]         step_r;
   logic                unused_bits;

   assign tick        = run_q && (presc_q == period_q);
   assign value_wr    = write && (address == ADDR_VALUE);
   assign step_r      = step_value(32'(value_q), down_q, bcd_q, NDIGITS);
   assign unused_bits = ^{writedata, step_r};

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      value_d  = value_q;
      run_d    = run_q;
      down_d   = down_q;
      bcd_d    = bcd_q;
      wrap_d   = wrap_q;
      period_d = period_q;
      blank_d  = blank_q;

      if (tick || !run_q) presc_d = '0;
      else                presc_d = presc_q + PERIOD_W'(1);

      if (write) begin
         unique case (address)
            ADDR_VALUE: value_d = writedata[VW-1:0];
            ADDR_CTRL: begin
               run_d  = writedata[CTRL_RUN];
               down_d = writedata[CTRL_DOWN];
               bcd_d  = writedata[CTRL_BCD];
               if (writedata[CTRL_WRAP]) wrap_d  = 1'b0;
               if (!writedata[CTRL_RUN]) presc_d = '0;
            end
            ADDR_PERIOD: begin
               period_d = writedata[PERIOD_W-1:0];
               presc_d  = '0;
            end
            ADDR_BLANK: blank_d = writedata[NDIGITS-1:0];
         endcase
      end

      // A same-cycle VALUE write swallows the tick; a wrap overrides the W1C above.
      if (tick && !value_wr) begin
         value_d = step_r[VW-1:0];
         if (step_r[32]) wrap_d = 1'b1;
      end
   end

   always_comb begin
      readdata_d = readdata_q;
      if (read) begin
         readdata_d = '0;
         unique case (address)
            ADDR_VALUE:  readdata_d = 32'(value_q);
            ADDR_CTRL: begin
               readdata_d[CTRL_RUN]  = run_q;
               readdata_d[CTRL_DOWN] = down_q;
               readdata_d[CTRL_BCD]  = bcd_q;
               readdata_d[CTRL_WRAP] = wrap_q;
            end
            ADDR_PERIOD: readdata_d = 32'(period_q);
            ADDR_BLANK:  readdata_d = 32'(blank_q);
         endcase
      end
   end

   // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         value_q    <= '0;
         run_q      <= 1'b0;
         down_q     <= 1'b0;
         bcd_q      <= 1'b0;
         wrap_q     <= 1'b0;
         period_q   <= PERIOD_RST;
         blank_q    <= '0;
         presc_q    <= '0;
         readdata_q <= '0;
      end else begin
         value_q    <= value_d;
         run_q      <= run_d;
         down_q     <= down_d;
         bcd_q      <= bcd_d;
         wrap_q     <= wrap_d;
         period_q   <= period_d;
         blank_q    <= blank_d;
         presc_q    <= presc_d;
         readdata_q <= readdata_d;
      end
   end

   assign readdata = readdata_q;

   for (genvar i = 0; i < NDIGITS; i++) begin : g_digit
      logic [6:0] seg;
      seg7decoder u_dec (
         .hex (value_q[4*i +: 4]),
         .seg (seg)
      );
      assign HEX[7*i +: 7] = blank_q[i] ? 7'h7F : seg;
   end

endmodule

// File: tb/tb_hexdisplay_ctrl.sv
// Directed self-checking bench for hexdisplay_ctrl with the default 6-digit setup.
module tb_hexdisplay_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  address;
   logic        write;
   logic [31:0] writedata;
   logic        read;
   logic [31:0] readdata;
   logic [41:0] HEX;

   int n_assert = 0;
   int n_fail   = 0;

   logic [31:0] rdat;

   hexdisplay_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .address   (address),
      .write     (write),
      .writedata (writedata),
      .read      (read),
      .readdata  (readdata),
      .HEX       (HEX)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] seg_of(input logic [3:0] d);
      case (d)
         4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
         4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
         4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
         4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
      endcase
   endfunction

   function automatic logic [41:0] exp_hex(input logic [23:0] v, input logic [5:0] b);
      logic [41:0] r;
      for (int i = 0; i < 6; i++)
         r[7*i +: 7] = b[i] ? 7'h7F : seg_of(v[4*i +: 4]);
      return r;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs change just after a falling edge; the rising edge in between samples them.
   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      address   = a;
      writedata = d;
      write     = 1'b1;
      @(negedge clk);
      write     = 1'b0;
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      address = a;
      read    = 1'b1;
      @(negedge clk);
      read    = 1'b0;
      d       = readdata;
   endtask

   initial begin
      reset     = 1'b1;
      address   = 2'd0;
      write     = 1'b0;
      writedata = '0;
      read      = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // Reset state
      check("rst_hex", HEX, {6{7'h40}});
      check("rst_readdata", readdata, 32'h0);
      rd(2'd0, rdat); check("rst_value", rdat, 32'h0);
      rd(2'd1, rdat); check("rst_ctrl", rdat, 32'h0);
      rd(2'd2, rdat); check("rst_period", rdat, 32'h00FF_FFFF);
      rd(2'd3, rdat); check("rst_blank", rdat, 32'h0);

      // 1. Reset mid-run
      wr(2'd0, 32'h0000_0123);
      wr(2'd1, 32'h1);
      rd(2'd0, rdat); check("run_value", rdat, 32'h123);
      repeat (2) @(negedge clk);
      check("run_hex", HEX, exp_hex(24'h000123, 6'h0));
      #2 reset = 1'b1;
      #1;
      check("async_rst_hex", HEX, {6{7'h40}});
      check("async_rst_readdata", readdata, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      rd(2'd0, rdat); check("post_rst_value", rdat, 32'h0);
      rd(2'd2, rdat); check("post_rst_period", rdat, 32'h00FF_FFFF);
      wr(2'd2, 32'h0);
      repeat (4) @(negedge clk);
      rd(2'd0, rdat); check("post_rst_no_tick", rdat, 32'h0);

      // 2. Tick period 3: one step every 4 cycles
      wr(2'd2, 32'h3);
      wr(2'd0, 32'h0);
      wr(2'd1, 32'h1);
      repeat (3) @(negedge clk);
      check("period_3cyc", HEX, exp_hex(24'h000000, 6'h0));
      @(negedge clk);
      check("period_4cyc", HEX, exp_hex(24'h000001, 6'h0));
      repeat (16) @(negedge clk);
      check("period_20cyc", HEX, exp_hex(24'h000005, 6'h0));
      wr(2'd1, 32'h0);
      rd(2'd0, rdat); check("period_stop_value", rdat, 32'h5);

      // 3. Hex wrap and W1C
      wr(2'd0, 32'h00FF_FFFF);
      wr(2'd2, 32'h0);
      wr(2'd1, 32'h1);
      @(negedge clk);
      check("hex_wrap_hex", HEX, exp_hex(24'h000000, 6'h0));
      rd(2'd1, rdat); check("wrap_set", rdat, 32'h101);
      wr(2'd1, 32'h101);
      rd(2'd1, rdat); check("wrap_w1c", rdat, 32'h001);
      wr(2'd1, 32'h0);
      rd(2'd0, rdat); check("hex_count", rdat, 32'h4);

      // 4. BCD down
      wr(2'd0, 32'h0000_0100);
      wr(2'd1, 32'h7);
      @(negedge clk);
      check("bcd_down_1", HEX, exp_hex(24'h000099, 6'h0));
      @(negedge clk);
      check("bcd_down_2", HEX, exp_hex(24'h000098, 6'h0));
      wr(2'd1, 32'h6);
      rd(2'd0, rdat); check("bcd_down_3", rdat, 32'h97);
      wr(2'd0, 32'h0);
      wr(2'd1, 32'h7);
      @(negedge clk);
      check("bcd_wrap_hex", HEX, exp_hex(24'h999999, 6'h0));
      wr(2'd1, 32'h6);
      rd(2'd1, rdat); check("bcd_wrap_ctrl", rdat, 32'h106);
      rd(2'd0, rdat); check("bcd_wrap_value", rdat, 32'h0099_9998);

      // 5. Simultaneous events
      wr(2'd1, 32'h100);
      wr(2'd0, 32'h00FF_FFFF);
      wr(2'd1, 32'h1);
      wr(2'd0, 32'h0000_ABCD);
      check("vwr_beats_tick", HEX, exp_hex(24'h00ABCD, 6'h0));
      wr(2'd1, 32'h0);
      rd(2'd1, rdat); check("vwr_no_wrap", rdat, 32'h0);
      rd(2'd0, rdat); check("vwr_then_step", rdat, 32'hABCE);
      wr(2'd0, 32'h00FF_FFFF);
      wr(2'd1, 32'h1);
      wr(2'd1, 32'h101);
      wr(2'd1, 32'h0);
      rd(2'd1, rdat); check("wrap_set_wins", rdat, 32'h100);

      // BCD up carry chain
      wr(2'd1, 32'h100);
      wr(2'd0, 32'h0000_0199);
      wr(2'd1, 32'h5);
      wr(2'd1, 32'h4);
      rd(2'd0, rdat); check("bcd_up", rdat, 32'h200);

      // 6. Blank and readback
      wr(2'd0, 32'h0012_3456);
      wr(2'd3, 32'h21);
      check("blank_hex", HEX, exp_hex(24'h123456, 6'h21));
      rd(2'd3, rdat); check("blank_read", rdat, 32'h21);
      address   = 2'd3;
      writedata = 32'h3;
      write     = 1'b1;
      read      = 1'b1;
      @(negedge clk);
      write = 1'b0;
      read  = 1'b0;
      check("rd_wr_prewrite", readdata, 32'h21);
      repeat (2) @(negedge clk);
      check("readdata_hold", readdata, 32'h21);
      rd(2'd3, rdat); check("blank_new", rdat, 32'h3);
      wr(2'd3, 32'hFFFF_FFFF);
      rd(2'd3, rdat); check("blank_unused_bits", rdat, 32'h3F);
      check("all_blank_hex", HEX, {6{7'h7F}});

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
